crc16_tx: RTL and testbench

CRC16_TX -- requirements
Module: crc16_tx

---
 rtl/crc16_tx.sv | 85 ++++++++
 tb/tb_crc16_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/crc16_tx.sv
// crc16_tx: bit-serial CRC-16 appender; emits the payload, then M(x)*x^16 mod P MSB-first.
// Optional CRC16_TX_ERR_INJECT_EN adds crc_corrupt, which inverts the frame's final CRC bit.
module crc16_tx #(
   parameter logic [15:0] POLYNOMIAL = 16'h1021
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_data,
   input  logic in_last,
   output logic in_ready,
`ifdef CRC16_TX_ERR_INJECT_EN
   input  logic crc_corrupt,
`endif
   output logic out_valid,
   output logic out_data,
   output logic out_last,
   input  logic out_ready,
   output logic busy
);
   typedef enum logic {DATA, CRC} state_t;
   state_t      state_q, state_d;
   logic [15:0] crc_q, crc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        out_data_q, out_data_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic        adv, acc_in, fb, flip;
   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = (state_q == DATA) && adv;
   assign acc_in    = in_valid && in_ready;
   assign fb        = in_data ^ crc_q[15];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = state_q == CRC;
`ifdef CRC16_TX_ERR_INJECT_EN
   logic corrupt_q;
   assign flip = corrupt_q;
   always_ff @(posedge clk)
      if (reset) corrupt_q <= 1'b0;
      else if (acc_in && in_last) corrupt_q <= crc_corrupt;
`else
   assign flip = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !out_ready;
      if (acc_in) begin
         out_data_d  = in_data;
         out_valid_d = 1'b1;
         out_last_d  = 1'b0;
         crc_d       = (crc_q << 1) ^ (fb ? POLYNOMIAL : 16'h0000);
         state_d     = in_last ? CRC : DATA;
         cnt_d       = in_last ? 4'd0 : cnt_q;
      end else if (state_q == CRC && adv) begin
         // Shifting out all 16 bits leaves crc_q at zero for the next frame.
         out_data_d  = crc_q[15] ^ (flip && cnt_q == 4'd15);
         out_valid_d = 1'b1;
         out_last_d  = cnt_q == 4'd15;
         crc_d       = crc_q << 1;
         cnt_d       = cnt_q + 4'd1;
         state_d     = cnt_q == 4'd15 ? DATA : CRC;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DATA;
         crc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end
endmodule

// File: tb/tb_crc16_tx.sv
// tb_crc16_tx: scoreboard bench; expected frames come from polynomial long division.
module tb_crc16_tx;
   logic clk = 0, reset = 1, in_valid = 0, in_data = 0, in_last = 0, out_ready = 0;
   logic in_ready, out_valid, out_data, out_last, busy;
`ifdef CRC16_TX_ERR_INJECT_EN
   logic crc_corrupt = 0;
`endif
   typedef struct {bit d; bit last; bit bad;} exp_t;
   exp_t exp_q[$];
   bit   rx_q[$];
   int   n_vec = 0, n_err = 0;
   bit   rdy_rand = 0;
   bit   stall_q = 0;
   logic [1:0] hold_q = 0;
   always #5 clk = ~clk;
   crc16_tx dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready),
`ifdef CRC16_TX_ERR_INJECT_EN
      .crc_corrupt(crc_corrupt),
`endif
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Remainder of the bit string (MSB first) divided by x^16 + 0x1021.
   function automatic logic [15:0] rem16(input bit b[$]);
      bit r[$];
      logic [16:0] p;
      logic [15:0] res;
      r = b;
      p = {1'b1, 16'h1021};
      for (int i = 0; i + 16 < r.size(); i++)
         if (r[i]) for (int j = 0; j <= 16; j++) r[i+j] = r[i+j] ^ p[16-j];
      for (int k = 0; k < 16; k++) res[15-k] = r[r.size()-16+k];
      return res;
   endfunction
   function automatic logic [15:0] model_crc(input bit m[$]);
      bit t[$];
      t = m;
      repeat (16) t.push_back(1'b0);
      return rem16(t);
   endfunction
   always @(posedge clk) begin
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end
   always @(negedge clk) begin
      exp_t e;
      if (reset) stall_q <= 0;
      else begin
         if (stall_q) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data_last", {out_data, out_last}, hold_q);
         end
         if (busy) chk("in_ready_in_crc", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", out_last, e.last);
               rx_q.push_back(out_data);
               if (out_last) begin
                  chk("checker_error", rem16(rx_q) != 0, e.bad);
                  rx_q.delete();
               end
            end
         end
         stall_q <= out_valid && !out_ready;
         hold_q  <= {out_data, out_last};
      end
   end
   task automatic send_bit(input bit b, input bit last, output int waits);
      bit got;
      got = 0;
      waits = 0;
      in_valid = 1;
      in_data = b;
      in_last = last;
      while (!got && waits < 300) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         if (!got) waits++;
      end
      if (!got) chk("accept_timeout", 0, 1);
      in_valid = 0;
      in_last = 0;
   endtask
   task automatic send_frame(input bit m[$], input logic [15:0] crc, input bit corrupt,
                             input bit gaps, output int w0);
      int w;
      foreach (m[i]) exp_q.push_back('{m[i], 1'b0, corrupt});
      for (int k = 15; k >= 0; k--) exp_q.push_back('{crc[k] ^ (corrupt && k == 0), k == 0, corrupt});
`ifdef CRC16_TX_ERR_INJECT_EN
      crc_corrupt = corrupt;
`endif
      foreach (m[i]) begin
         send_bit(m[i], i == m.size() - 1, w);
         if (i == 0) w0 = w;
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
   endtask
   initial begin
      bit m[$];
      string s;
      byte c;
      int w, t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 0;
      m = '{1'b1};
      send_frame(m, 16'h1021, 0, 0, w);
      s = "123456789";
      m.delete();
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         for (int k = 7; k >= 0; k--) m.push_back(c[k]);
      end
      send_frame(m, 16'h31C3, 0, 0, w);
      m = '{1'b1};
      send_frame(m, 16'h1021, 0, 0, w);
      m = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      send_frame(m, model_crc(m), 0, 0, w);
      chk("b2b_wait_cycles", w, 16);
      m = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      send_frame(m, model_crc(m), 0, 0, w);
      repeat (6) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      chk("midcrc_rst_valid", out_valid, 0);
      chk("midcrc_rst_busy", busy, 0);
      exp_q.delete();
      rx_q.delete();
      reset = 0;
      m = '{1'b1};
      send_frame(m, 16'h1021, 0, 0, w);
`ifdef CRC16_TX_ERR_INJECT_EN
      send_frame(m, 16'h1021, 1, 0, w);
`endif
      rdy_rand = 1;
      for (int f = 0; f < 25; f++) begin
         m.delete();
         repeat ($urandom_range(1, 40)) m.push_back(1'($urandom_range(0, 1)));
         send_frame(m, model_crc(m), 0, 1, w);
      end
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("drain_remaining", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
